seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath. It replaces single-cycle combinational multiply/divide with
//  iterative units behind a start/done handshake. Sits between the Y/B operand registers and the C (HI:LO) register;
//  the control unit pulses start and waits for done. Opcode encoding is unchanged from the existing ISA.
// PARAMETERS
//  WIDTH   32   operand width (power of 2, >=8); C is 2*WIDTH
//  SHW     $clog2(WIDTH)  shift-amount bits taken from b_in[SHW-1:0]
// PORTS
//  clock      in   1        rising-edge clock
//  clear      in   1        synchronous, active-high reset
//  start      in   1        request; operands/opcode captured on the edge where start=1 and busy=0
//  opcode     in   5        ISA opcode (add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000,
//                           rol 01001, and 01010, or 01011, addi 01100, andi 01101, ori 01110, mul 01111,
//                           div 10000, neg 10001, not 10010, ld 00000, ldi 00001, st 00010, br 10011)
//  inc_pc     in   1        captured with start; overrides opcode: result = b_in+1
//  branch_ok  in   1        captured with start; CON FF result for br
//  y_in       in   WIDTH    operand A (Y register)
//  b_in       in   WIDTH    operand B (bus)
//  c_out      out  2*WIDTH  result; HI=c_out[2W-1:W], LO=c_out[W-1:0]
//  busy       out  1        high from capture until the cycle done is asserted (inclusive of neither)
//  done       out  1        one-cycle pulse; c_out valid from this cycle until the next done
// BEHAVIOUR
//  Reset: state=IDLE, c_out=0, busy=0, done=0; all internal accumulators cleared. Clear mid-op aborts;
//   no done is issued for the aborted op.
//  FSM: IDLE -> (start, single-cycle op) -> IDLE with done at t+1
//       IDLE -> (start, mul/div) -> RUN (WIDTH cycles, counter WIDTH-1..0) -> FIX (1 cycle) -> IDLE, done at t+WIDTH+2
//  Single-cycle ops (latency 1, HI=0 unless noted):
//   add/addi/ld/ldi/st = y+b mod 2^W; sub = y-b; and/andi, or/ori bitwise; neg = -b; not = ~b
//   shl/shr logical, shra arithmetic, rol/ror rotate of y by b[SHW-1:0]; amount 0 -> y unchanged
//   br: LO = branch_ok ? y+b : y; inc_pc: LO = b+1 (HI=0); undefined opcode: c_out=0, done still pulses
//  mul: signed two's-complement, radix-2 shift-add on magnitudes, sign applied in FIX; c_out = full 2W product
//  div: signed restoring division on magnitudes; LO=quotient truncated toward zero, HI=remainder with sign of
//   dividend y. Divide by zero: LO = all-ones, HI = y, same latency (no early exit).
//   Most-negative / -1: LO = most-negative (wraps), HI=0.
//  start while busy=1 is ignored (no capture, no effect). start in the same cycle as done is accepted
//   (back-to-back); done for the new op follows its own latency.
//  c_out is registered, changes only on the done cycle or clear; operand inputs may change freely after capture.
// TESTING (WIDTH=32)
//  1 clear mid-mul at RUN count 10 -> next cycle busy=0, done=0, c_out=0; no later done pulse
//  2 add y=0xFFFFFFFF,b=1 -> done t+1, c_out=0x0000000000000000; sub y=5,b=7 -> LO=0xFFFFFFFE
//  3 mul y=-3,b=7 -> done at t+34, c_out=0xFFFFFFFF_FFFFFFEB; mul 0x80000000*0x80000000 -> 0x40000000_00000000
//  4 div y=-7,b=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); div y=9,b=0 -> LO=0xFFFFFFFF, HI=9, done t+34
//  5 rol y=0x80000001,b=33 -> LO=0x00000003; shra y=0x80000000,b=31 -> LO=0xFFFFFFFF
//  6 start mul, re-pulse start(add) while busy -> ignored; start add on done cycle -> done next cycle, LO=y+b

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/shift/add ops finish one clock after capture, signed mul/div iterate
// WIDTH cycles plus a sign-fix cycle. c_out holds the most recently completed result.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic               inc_pc,
    input  logic               branch_ok,
    input  logic [WIDTH-1:0]   y_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] c_out,
    output logic               busy,
    output logic               done
);
    localparam int unsigned W = WIDTH;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShra = 5'b00110;
    localparam logic [4:0] OpShl  = 5'b00111;
    localparam logic [4:0] OpRor  = 5'b01000;
    localparam logic [4:0] OpRol  = 5'b01001;
    localparam logic [4:0] OpAnd  = 5'b01010;
    localparam logic [4:0] OpOr   = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e         state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [W:0]     hi_q, hi_d;       // mul: product upper half + carry; div: partial remainder
    logic [W-1:0]   lo_q, lo_d;       // mul: multiplier shifting out; div: dividend -> quotient
    logic [W-1:0]   opd_q, opd_d;
    logic [W-1:0]   y_q, y_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           dz_q, dz_d;
    logic [2*W-1:0] c_q, c_d;
    logic           done_q, done_d;

    logic [SHW-1:0] sh;
    logic [SHW:0]   sh_inv;
    logic [W-1:0]   y_mag, b_mag, lo_res, quo, rem;
    logic [W:0]     mul_sum, div_shift;
    logic [W+1:0]   div_trial;
    logic [2*W-1:0] prod_mag;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        y_d      = y_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        c_d      = c_q;
        done_d   = 1'b0;

        sh     = b_in[SHW-1:0];
        sh_inv = (SHW+1)'(W) - {1'b0, sh};
        y_mag  = y_in[W-1] ? -y_in : y_in;
        b_mag  = b_in[W-1] ? -b_in : b_in;

        lo_res = '0;
        case (opcode)
            OpLd, OpLdi, OpSt, OpAdd, OpAddi: lo_res = y_in + b_in;
            OpSub:         lo_res = y_in - b_in;
            OpShr:         lo_res = y_in >> sh;
            OpShra:        lo_res = $signed(y_in) >>> sh;
            OpShl:         lo_res = y_in << sh;
            // Shift by sh_inv == W yields zero, so amount 0 leaves y unchanged.
            OpRor:         lo_res = (y_in >> sh) | (y_in << sh_inv);
            OpRol:         lo_res = (y_in << sh) | (y_in >> sh_inv);
            OpAnd, OpAndi: lo_res = y_in & b_in;
            OpOr, OpOri:   lo_res = y_in | b_in;
            OpNeg:         lo_res = -b_in;
            OpNot:         lo_res = ~b_in;
            OpBr:          lo_res = branch_ok ? y_in + b_in : y_in;
            default:       lo_res = '0;
        endcase
        if (inc_pc) begin
            lo_res = b_in + W'(1);
        end

        mul_sum   = hi_q + {1'b0, {W{lo_q[0]}} & opd_q};
        div_shift = {hi_q[W-1:0], lo_q[W-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opd_q};
        prod_mag  = {hi_q[W-1:0], lo_q};
        quo       = neg_q ? -lo_q : lo_q;
        rem       = rneg_q ? -hi_q[W-1:0] : hi_q[W-1:0];

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (!inc_pc && (opcode == OpMul || opcode == OpDiv)) begin
                        state_d  = StRun;
                        cnt_d    = SHW'(W - 1);
                        is_div_d = (opcode == OpDiv);
                        hi_d     = '0;
                        lo_d     = y_mag;
                        opd_d    = b_mag;
                        y_d      = y_in;
                        neg_d    = y_in[W-1] ^ b_in[W-1];
                        rneg_d   = y_in[W-1];
                        dz_d     = (b_in == '0);
                    end else begin
                        c_d    = {{W{1'b0}}, lo_res};
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (is_div_q) begin
                    hi_d = div_trial[W+1] ? div_shift : div_trial[W:0];
                    lo_d = {lo_q[W-2:0], ~div_trial[W+1]};
                end else begin
                    hi_d = {1'b0, mul_sum[W:1]};
                    lo_d = {mul_sum[0], lo_q[W-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (is_div_q) begin
                    c_d = dz_q ? {y_q, {W{1'b1}}} : {rem, quo};
                end else begin
                    c_d = neg_q ? -prod_mag : prod_mag;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            y_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            c_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            y_q      <= y_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            c_q      <= c_d;
            done_q   <= done_d;
        end
    end

    assign c_out = c_q;
    assign busy  = (state_q != StIdle);
    assign done  = done_q;

endmodule
